// File: rtl/mips_regfile_pkg.sv
// ============================================================================
// Module  : mips_regfile_pkg
// Brief   : Shared types and constants for the MIPS multi-port register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage : mips_regfile_pkg

`default_nettype wire

// File: rtl/mips_regfile_scoreboard.sv
// ============================================================================
// Module  : mips_regfile_scoreboard
// Brief   : Per-register busy bits; set has priority over writeback clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_regfile_scoreboard
    import mips_regfile_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int NUM_RD    = 2,
    parameter int HARD_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_busy_set,
    input  logic [ADDR_W-1:0]        i_busy_reg,
    input  logic                     i_clr_a,
    input  logic [ADDR_W-1:0]        i_clr_idx_a,
    input  logic                     i_clr_b,
    input  logic [ADDR_W-1:0]        i_clr_idx_b,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_idx,
    output logic [NUM_RD-1:0]        o_rd_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic             w_set;

    // A hard-wired zero register can never have an outstanding producer.
    assign w_set = i_busy_set &&
                   !((HARD_ZERO != 0) && (i_busy_reg == ADDR_W'(ZERO_REG)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_set && (i_busy_reg == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if ((i_clr_a && (i_clr_idx_a == ADDR_W'(i))) ||
                             (i_clr_b && (i_clr_idx_b == ADDR_W'(i)))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_lookup
        assign o_rd_busy[p] = r_busy[i_rd_idx[p*ADDR_W +: ADDR_W]];
    end

endmodule : mips_regfile_scoreboard

`default_nettype wire

// File: rtl/mips_regfile_mp.sv
// ============================================================================
// Module  : mips_regfile_mp
// Brief   : Multi-port register file (NUM_RD reads, two writes, B wins) with
//           busy scoreboard. Define REGFILE_BYPASS_EN for write->read bypass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_regfile_mp
    import mips_regfile_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int NUM_RD    = 2,
    parameter int HARD_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] read_reg,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_busy,
    input  logic [ADDR_W-1:0]        write_reg_a,
    input  logic [DATA_W-1:0]        write_data_a,
    input  logic                     reg_write_a,
    input  logic [ADDR_W-1:0]        write_reg_b,
    input  logic [DATA_W-1:0]        write_data_b,
    input  logic                     reg_write_b,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_reg
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              w_we_a;
    logic              w_we_b;
    logic [NUM_RD-1:0] w_sb_busy;

    assign w_we_a = reg_write_a &&
                    !((HARD_ZERO != 0) && (write_reg_a == ADDR_W'(ZERO_REG)));
    assign w_we_b = reg_write_b &&
                    !((HARD_ZERO != 0) && (write_reg_b == ADDR_W'(ZERO_REG)));

    // Port B is applied last so it overrides A on a same-index collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_we_a) begin
                r_regs[write_reg_a] <= write_data_a;
            end
            if (w_we_b) begin
                r_regs[write_reg_b] <= write_data_b;
            end
        end
    end

    mips_regfile_scoreboard #(
        .ADDR_W    (ADDR_W),
        .NUM_RD    (NUM_RD),
        .HARD_ZERO (HARD_ZERO)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_busy_set  (busy_set),
        .i_busy_reg  (busy_reg),
        .i_clr_a     (reg_write_a),
        .i_clr_idx_a (write_reg_a),
        .i_clr_b     (reg_write_b),
        .i_clr_idx_b (write_reg_b),
        .i_rd_idx    (read_reg),
        .o_rd_busy   (w_sb_busy)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_idx;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_idx = read_reg[p*ADDR_W +: ADDR_W];

        always_comb begin
            w_data = r_regs[w_idx];
            w_busy = w_sb_busy[p];
`ifdef REGFILE_BYPASS_EN
            // A forwarded value is complete unless a new producer claims the register now.
            if (w_we_b && (write_reg_b == w_idx)) begin
                w_data = write_data_b;
                w_busy = busy_set && (busy_reg == w_idx);
            end else if (w_we_a && (write_reg_a == w_idx)) begin
                w_data = write_data_a;
                w_busy = busy_set && (busy_reg == w_idx);
            end
`endif
            if ((HARD_ZERO != 0) && (w_idx == ADDR_W'(ZERO_REG))) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign read_data[p*DATA_W +: DATA_W] = w_data;
        assign read_busy[p]                  = w_busy;
    end

endmodule : mips_regfile_mp

`default_nettype wire
